// File: rtl/arm_dp_pkg.sv
// arm_dp_pkg: shared opcode encodings, NZCV bit positions and helpers for the DP execute unit
package arm_dp_pkg;
    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_EOR = 4'h1;
    localparam logic [3:0] OP_SUB = 4'h2;
    localparam logic [3:0] OP_RSB = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_ADC = 4'h5;
    localparam logic [3:0] OP_SBC = 4'h6;
    localparam logic [3:0] OP_RSC = 4'h7;
    localparam logic [3:0] OP_TST = 4'h8;
    localparam logic [3:0] OP_TEQ = 4'h9;
    localparam logic [3:0] OP_CMP = 4'hA;
    localparam logic [3:0] OP_CMN = 4'hB;
    localparam logic [3:0] OP_ORR = 4'hC;
    localparam logic [3:0] OP_MOV = 4'hD;
    localparam logic [3:0] OP_BIC = 4'hE;
    localparam logic [3:0] OP_MVN = 4'hF;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] nzcv_t;

    // TST/TEQ/CMP/CMN (10xx) only produce flags; their result never reaches Rd
    function automatic logic is_compare(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction
endpackage

// File: rtl/dp_alu_core.sv
// dp_alu_core: combinational 33-bit add/logic datapath with NZCV generation
//   opcode     : ARM DP opcode
//   op_a/op_b  : Rn value / shifter operand
//   shift_cout : shifter carry-out, becomes C for logical ops
//   s_bit      : when 0 the incoming flags pass through unchanged
//   flags_in   : current {N,Z,C,V}
//   result     : computed value
//   flags_out  : next {N,Z,C,V}
//   wb_en      : result goes to Rd (0 for compare/test ops)
module dp_alu_core
    import arm_dp_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        shift_cout,
    input  logic        s_bit,
    input  logic [3:0]  flags_in,
    output logic [31:0] result,
    output logic [3:0]  flags_out,
    output logic        wb_en
);
    logic        rev;
    logic        inv;
    logic        arith;
    logic        cin;
    logic [31:0] x;
    logic [31:0] y;
    logic [32:0] sum;
    logic [31:0] logic_r;
    nzcv_t       nf;

    always_comb begin
        // reverse ops swap operands so one adder serves every arithmetic opcode
        rev   = opcode == OP_RSB || opcode == OP_RSC;
        inv   = rev || opcode == OP_SUB || opcode == OP_SBC || opcode == OP_CMP;
        arith = inv || opcode == OP_ADD || opcode == OP_ADC || opcode == OP_CMN;
        // carry-chaining ops take C; plain subtracts add 1 to complete ~y+1
        cin   = (opcode == OP_ADC || opcode == OP_SBC || opcode == OP_RSC) ? flags_in[FLAG_C] : inv;
        x     = rev ? op_b : op_a;
        y     = inv ? ~(rev ? op_a : op_b) : op_b;
        sum   = {1'b0, x} + {1'b0, y} + {32'b0, cin};
        case (opcode)
            OP_AND, OP_TST: logic_r = op_a & op_b;
            OP_EOR, OP_TEQ: logic_r = op_a ^ op_b;
            OP_ORR:         logic_r = op_a | op_b;
            OP_MOV:         logic_r = op_b;
            OP_BIC:         logic_r = op_a & ~op_b;
            default:        logic_r = ~op_b;
        endcase
        result     = arith ? sum[31:0] : logic_r;
        nf[FLAG_N] = result[31];
        nf[FLAG_Z] = result == 32'd0;
        nf[FLAG_C] = arith ? sum[32] : shift_cout;
        nf[FLAG_V] = arith ? (x[31] == y[31]) && (result[31] != x[31]) : flags_in[FLAG_V];
        flags_out  = s_bit ? nf : flags_in;
        wb_en      = !is_compare(opcode);
    end
endmodule

// File: rtl/dp_flag_unit.sv
// dp_flag_unit: two-stage pipelined ARM data-processing execute unit driving the flag register
//   clk, reset          : clock, asynchronous active-high reset
//   in_valid/in_ready   : request handshake (stage A)
//   opcode, op_a, op_b  : operation and operands
//   shift_cout, s_bit   : shifter carry-out, flag-update enable
//   flags_in            : current {N,Z,C,V}, sampled with the request
//   out_valid/out_ready : result handshake (stage B)
//   result, flags_out   : computed value and next {N,Z,C,V}
//   fr_ld               : flag register load strobe, one pulse per transferred S request
//   wb_en               : result is written to Rd
module dp_flag_unit
    import arm_dp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  opcode,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        shift_cout,
    input  logic        s_bit,
    input  logic [3:0]  flags_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic [3:0]  flags_out,
    output logic        fr_ld,
    output logic        wb_en
);
    logic        a_valid;
    logic [3:0]  a_op;
    logic [31:0] a_a;
    logic [31:0] a_b;
    logic        a_cout;
    logic        a_s;
    nzcv_t       a_flags;
    logic        b_valid;
    logic [31:0] b_result;
    nzcv_t       b_flags;
    logic        b_s;
    logic        b_wb;
    logic [31:0] alu_result;
    nzcv_t       alu_flags;
    logic        alu_wb;
    logic        b_accept;

    // in_ready depends only on state and out_ready, never on in_valid
    assign b_accept = !b_valid || out_ready;
    assign in_ready = !a_valid || b_accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_valid <= 1'b0;
            a_op    <= 4'd0;
            a_a     <= 32'd0;
            a_b     <= 32'd0;
            a_cout  <= 1'b0;
            a_s     <= 1'b0;
            a_flags <= 4'd0;
        end else if (in_ready) begin
            a_valid <= in_valid;
            if (in_valid) begin
                a_op    <= opcode;
                a_a     <= op_a;
                a_b     <= op_b;
                a_cout  <= shift_cout;
                a_s     <= s_bit;
                a_flags <= flags_in;
            end
        end
    end

    dp_alu_core u_alu (
        .opcode     (a_op),
        .op_a       (a_a),
        .op_b       (a_b),
        .shift_cout (a_cout),
        .s_bit      (a_s),
        .flags_in   (a_flags),
        .result     (alu_result),
        .flags_out  (alu_flags),
        .wb_en      (alu_wb)
    );

    // stage B payload only loads with a valid request, so stalled outputs hold
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            b_valid  <= 1'b0;
            b_result <= 32'd0;
            b_flags  <= 4'd0;
            b_s      <= 1'b0;
            b_wb     <= 1'b0;
        end else if (b_accept) begin
            b_valid <= a_valid;
            if (a_valid) begin
                b_result <= alu_result;
                b_flags  <= alu_flags;
                b_s      <= a_s;
                b_wb     <= alu_wb;
            end
        end
    end

    assign out_valid = b_valid;
    assign result    = b_result;
    assign flags_out = b_flags;
    assign wb_en     = b_wb;
    assign fr_ld     = b_valid && out_ready && b_s;
endmodule
